// File: rtl/lsq_param.sv
// rtl/lsq_param.sv - parameterised in-order load/store queue with CDB wakeup, commit tracking and rollback
module lsq_param #(
  parameter int DEPTH = 16,
  parameter int ROB_W = 4,
  parameter int DATA_W = 32,
  parameter int OP_W = 6,
  parameter int NCDB = 2,
  parameter int AF_MARGIN = 5,
  parameter logic [DATA_W-1:0] IO_ADDR = 32'h30000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       in_valid,
  input  logic [OP_W-1:0]            in_op,
  input  logic                       in_is_store,
  input  logic [DATA_W-1:0]          in_v1,
  input  logic [DATA_W-1:0]          in_v2,
  input  logic [ROB_W-1:0]           in_q1,
  input  logic [ROB_W-1:0]           in_q2,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [ROB_W-1:0]           in_rob_id,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*ROB_W-1:0]      cdb_rob_id,
  input  logic [NCDB*DATA_W-1:0]     cdb_data,
  input  logic                       commit_valid,
  input  logic [ROB_W-1:0]           commit_rob_id,
  input  logic                       rollback,
  input  logic [ROB_W-1:0]           head_io_rob_id,
  output logic [ROB_W-1:0]           io_rob_id,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [OP_W-1:0]            mem_op,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [ROB_W-1:0]           mem_rob_id,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - AF_MARGIN);

  logic [DEPTH-1:0]  busy, cmt, is_st;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [ROB_W-1:0]  q1_q  [DEPTH];
  logic [ROB_W-1:0]  q2_q  [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [IW-1:0]     head, tail, ls, ls_span;
  logic              ls_vld, mem_is_st;
  logic [DATA_W-1:0] head_addr, enq_v1, enq_v2;
  logic [ROB_W-1:0]  enq_q1, enq_q2;
  logic              head_ready, out_free, issue, enq;

  assign head_addr  = v1_q[head] + imm_q[head];
  assign out_free   = !mem_valid || mem_ready;
  assign head_ready = busy[head] && (q1_q[head] == '0) && (q2_q[head] == '0) &&
                      (is_st[head] ? cmt[head]
                                   : (head_addr != IO_ADDR || head_io_rob_id == rob_q[head]));
  assign issue       = rdy && !rollback && head_ready && out_free;
  assign enq         = rdy && !rollback && in_valid && (count != FULL);
  assign io_rob_id   = (busy[head] && !is_st[head] && head_addr == IO_ADDR) ? rob_q[head] : '0;
  assign almost_full = count >= AF_LVL;
  assign ls_span     = ls - head;

  // descending scan so the lowest matching channel is applied last and wins
  always_comb begin
    enq_v1 = in_v1;
    enq_q1 = in_q1;
    enq_v2 = in_v2;
    enq_q2 = in_q2;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && in_q1 != '0 && cdb_rob_id[c*ROB_W +: ROB_W] == in_q1) begin
        enq_v1 = cdb_data[c*DATA_W +: DATA_W];
        enq_q1 = '0;
      end
      if (cdb_valid[c] && in_q2 != '0 && cdb_rob_id[c*ROB_W +: ROB_W] == in_q2) begin
        enq_v2 = cdb_data[c*DATA_W +: DATA_W];
        enq_q2 = '0;
      end
    end
  end

  // entry payload is only meaningful while busy, so it carries no reset
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int c = NCDB - 1; c >= 0; c--) begin
          if (busy[i] && cdb_valid[c] && q1_q[i] != '0 && cdb_rob_id[c*ROB_W +: ROB_W] == q1_q[i]) begin
            v1_q[i] <= cdb_data[c*DATA_W +: DATA_W];
            q1_q[i] <= '0;
          end
          if (busy[i] && cdb_valid[c] && q2_q[i] != '0 && cdb_rob_id[c*ROB_W +: ROB_W] == q2_q[i]) begin
            v2_q[i] <= cdb_data[c*DATA_W +: DATA_W];
            q2_q[i] <= '0;
          end
        end
      end
      if (enq) begin
        op_q[tail]  <= in_op;
        is_st[tail] <= in_is_store;
        v1_q[tail]  <= enq_v1;
        q1_q[tail]  <= enq_q1;
        v2_q[tail]  <= enq_v2;
        q2_q[tail]  <= enq_q2;
        imm_q[tail] <= in_imm;
        rob_q[tail] <= in_rob_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      cmt        <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ls         <= '0;
      ls_vld     <= 1'b0;
      mem_valid  <= 1'b0;
      mem_is_st  <= 1'b0;
      mem_op     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rob_id <= '0;
    end else if (rdy) begin
      if (rollback) begin
        // keep only the committed-store run head..last_store
        for (int i = 0; i < DEPTH; i++) begin
          if (!(ls_vld && (IW'(i) - head) <= ls_span)) begin
            busy[i] <= 1'b0;
            cmt[i]  <= 1'b0;
          end
        end
        if (ls_vld) begin
          tail  <= ls + 1'b1;
          count <= {1'b0, ls_span} + 1'b1;
        end else begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end
        if (mem_valid && (!mem_is_st || mem_ready)) mem_valid <= 1'b0;
      end else begin
        if (issue && ls_vld && ls == head) ls_vld <= 1'b0;
        if (commit_valid) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && !cmt[i] && rob_q[i] == commit_rob_id) begin
              cmt[i] <= 1'b1;
              if (is_st[i]) begin
                ls     <= IW'(i);
                ls_vld <= 1'b1;
              end
            end
          end
        end
        if (issue) begin
          busy[head] <= 1'b0;
          cmt[head]  <= 1'b0;
          head       <= head + 1'b1;
          mem_valid  <= 1'b1;
          mem_is_st  <= is_st[head];
          mem_op     <= op_q[head];
          mem_addr   <= head_addr;
          mem_wdata  <= is_st[head] ? v2_q[head] : '0;
          mem_rob_id <= rob_q[head];
        end else if (mem_ready) begin
          mem_valid <= 1'b0;
        end
        if (enq) begin
          busy[tail] <= 1'b1;
          cmt[tail]  <= 1'b0;
          tail       <= tail + 1'b1;
        end
        count <= count + CW'(enq) - CW'(issue);
      end
    end
  end
endmodule

// File: tb/tb_lsq_param.sv
// tb/tb_lsq_param.sv - randomized and directed bench for lsq_param against a queue-level reference model
module tb_lsq_param;
  localparam int DEPTH = 16;
  localparam int NCDB = 2;
  localparam logic [31:0] IO = 32'h30000;

  logic clk = 1'b0;
  logic rst, rdy, in_valid, in_is_store, commit_valid, rollback, mem_valid, mem_ready, almost_full;
  logic [5:0]  in_op, mem_op;
  logic [31:0] in_v1, in_v2, in_imm, mem_addr, mem_wdata;
  logic [3:0]  in_q1, in_q2, in_rob_id, commit_rob_id, head_io_rob_id, io_rob_id, mem_rob_id;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_data;
  logic [4:0]  count;

  lsq_param dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_op(in_op), .in_is_store(in_is_store),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2), .in_imm(in_imm), .in_rob_id(in_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .rollback(rollback),
    .head_io_rob_id(head_io_rob_id), .io_rob_id(io_rob_id), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rob_id(mem_rob_id),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    bit          st;
    logic [31:0] v1, v2, imm;
    logic [3:0]  q1, q2, rob;
    bit          cm;
  } ent_t;

  ent_t        mq[$];
  int          ls = -1;
  bit          m_valid, m_st;
  logic [5:0]  m_op;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_rob;
  int          n_tests = 0, n_fail = 0;
  logic [3:0]  rob_ctr = 4'd5;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int cdb_hit(logic [3:0] q);
    for (int c = 0; c < NCDB; c++)
      if (cdb_valid[c] && q != 0 && cdb_rob_id[c*4 +: 4] == q) return c;
    return -1;
  endfunction

  function automatic ent_t wake(ent_t e);
    int c;
    c = cdb_hit(e.q1);
    if (c >= 0) begin e.v1 = cdb_data[c*32 +: 32]; e.q1 = 0; end
    c = cdb_hit(e.q2);
    if (c >= 0) begin e.v2 = cdb_data[c*32 +: 32]; e.q2 = 0; end
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    ls = -1;
    m_valid = 0; m_st = 0; m_op = 0; m_addr = 0; m_wdata = 0; m_rob = 0;
  endtask

  task automatic model_step();
    bit iss = 0;
    int sz0 = mq.size();
    ent_t e, n;
    logic [31:0] ha = 0;
    if (!rdy) return;
    if (sz0 > 0) begin
      e = mq[0];
      ha = e.v1 + e.imm;
      iss = !rollback && e.q1 == 0 && e.q2 == 0 && (!m_valid || mem_ready) &&
            (e.st ? e.cm : (ha != IO || head_io_rob_id == e.rob));
    end
    if (rollback) begin
      if (ls >= 0) begin
        while (mq.size() > ls + 1) void'(mq.pop_back());
      end else mq.delete();
      if (m_valid && (!m_st || mem_ready)) m_valid = 0;
    end else begin
      if (commit_valid)
        foreach (mq[i]) begin
          n = mq[i];
          if (!n.cm && n.rob == commit_rob_id) begin
            n.cm = 1;
            if (n.st) ls = i;
            mq[i] = n;
          end
        end
      if (iss) begin
        m_valid = 1; m_op = e.op; m_addr = ha; m_wdata = e.st ? e.v2 : 0; m_rob = e.rob; m_st = e.st;
      end else if (mem_ready) m_valid = 0;
    end
    foreach (mq[i]) mq[i] = wake(mq[i]);
    if (!rollback) begin
      if (iss) begin
        void'(mq.pop_front());
        ls = (ls <= 0) ? -1 : ls - 1;
      end
      if (in_valid && sz0 < DEPTH) begin
        n.op = in_op; n.st = in_is_store; n.v1 = in_v1; n.v2 = in_v2; n.imm = in_imm;
        n.q1 = in_q1; n.q2 = in_q2; n.rob = in_rob_id; n.cm = 0;
        mq.push_back(wake(n));
      end
    end
  endtask

  task automatic compare();
    logic [3:0] eio = 0;
    if (mq.size() > 0 && !mq[0].st && mq[0].v1 + mq[0].imm == IO) eio = mq[0].rob;
    chk("count", count, mq.size());
    chk("almost_full", almost_full, mq.size() >= 11);
    chk("io_rob_id", io_rob_id, eio);
    chk("mem_valid", mem_valid, m_valid);
    if (m_valid) begin
      chk("mem_op", mem_op, m_op);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_rob_id", mem_rob_id, m_rob);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    in_valid = 0; cdb_valid = 0; commit_valid = 0; rollback = 0; rdy = 1;
  endtask

  task automatic enq(input bit st, input logic [31:0] v1, v2, imm, input logic [3:0] q1, q2, rob);
    in_valid = 1; in_is_store = st; in_op = 6'($urandom); in_v1 = v1; in_v2 = v2; in_imm = imm;
    in_q1 = q1; in_q2 = q2; in_rob_id = rob;
    tick();
    in_valid = 0;
  endtask

  task automatic cmt(input logic [3:0] rob);
    commit_valid = 1; commit_rob_id = rob;
    tick();
    commit_valid = 0;
  endtask

  task automatic rand_inputs();
    int j = -1;
    bit ok = 1;
    rdy = ($urandom % 10) != 0;
    mem_ready = ($urandom % 4) != 0;
    rollback = ($urandom % 50) == 0;
    in_valid = ($urandom % 2) && mq.size() < 10;
    in_is_store = $urandom % 2;
    in_op = 6'($urandom);
    in_v1 = ($urandom % 6 == 0) ? IO : $urandom % 65536;
    in_imm = (in_v1 == IO) ? 0 : $urandom % 256;
    in_v2 = $urandom;
    in_q1 = ($urandom % 3 == 0) ? 4'($urandom_range(1, 4)) : 4'd0;
    in_q2 = ($urandom % 3 == 0) ? 4'($urandom_range(1, 4)) : 4'd0;
    in_rob_id = rob_ctr;
    if (in_valid && rdy && !rollback) rob_ctr = (rob_ctr == 15) ? 4'd5 : rob_ctr + 1;
    for (int c = 0; c < NCDB; c++) begin
      cdb_valid[c] = $urandom % 2;
      cdb_rob_id[c*4 +: 4] = 4'($urandom_range(1, 4));
      cdb_data[c*32 +: 32] = $urandom;
    end
    head_io_rob_id = (mq.size() > 0 && $urandom % 3 == 0) ? mq[0].rob : 4'd0;
    foreach (mq[i]) begin
      if (j < 0 && mq[i].st && !mq[i].cm) j = i;
      if (j < 0 && !(mq[i].st && mq[i].cm)) ok = 0;
    end
    commit_valid = (j >= 0) && ok && ($urandom % 3 == 0);
    commit_rob_id = (j >= 0) ? mq[j].rob : 4'd0;
  endtask

  initial begin
    rst = 0; idle(); mem_ready = 1; head_io_rob_id = 0; commit_rob_id = 0;
    in_is_store = 0; in_op = 0; in_v1 = 0; in_v2 = 0; in_imm = 0; in_q1 = 0; in_q2 = 0; in_rob_id = 0;
    cdb_rob_id = 0; cdb_data = 0;
    model_reset();
    #12;
    chk("rst_count", count, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_io_rob_id", io_rob_id, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk) rst = 1;

    // dependent load woken by CDB channel 1 (channel 0 carries a different tag)
    enq(0, 32'h5555, 0, 4, 4'd3, 0, 4'd5);
    cdb_valid = 2'b10; cdb_rob_id = {4'd3, 4'd7}; cdb_data = {32'h100, 32'hbad};
    tick();
    cdb_valid = 0;
    for (int k = 0; k < 4 && !mem_valid; k++) tick();
    chk("cdb_wake_valid", mem_valid, 1);
    chk("cdb_wake_addr", mem_addr, 32'h104);
    tick();

    // store waits for commit, then payload holds under backpressure
    mem_ready = 0;
    enq(1, 32'h200, 32'hdead, 8, 0, 0, 4'd6);
    tick(); tick();
    chk("store_uncommitted", mem_valid, 0);
    cmt(4'd6);
    tick();
    chk("store_issue", mem_valid, 1);
    chk("store_wdata", mem_wdata, 32'hdead);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("store_stable_addr", mem_addr, 32'h208);
      chk("store_stable_wdata", mem_wdata, 32'hdead);
    end
    mem_ready = 1;
    tick();
    chk("store_drop", mem_valid, 0);

    // rollback keeps committed store S1, drops S2 and L1
    mem_ready = 0;
    enq(1, 32'h10, 32'h11, 0, 0, 0, 4'd7);
    cmt(4'd7);
    enq(1, 32'h20, 32'h22, 0, 0, 0, 4'd8);
    cmt(4'd8);
    enq(1, 32'h30, 32'h33, 0, 0, 0, 4'd9);
    enq(0, 32'h40, 0, 0, 0, 0, 4'd10);
    rollback = 1; tick(); rollback = 0;
    chk("rb_count", count, 1);
    chk("rb_store_kept", mem_valid, 1);
    mem_ready = 1;
    tick();
    chk("rb_s1_issue", mem_rob_id, 8);
    tick();
    chk("rb_empty", count, 0);

    // pending load is dropped by rollback
    mem_ready = 0;
    enq(0, 32'h50, 0, 0, 0, 0, 4'd11);
    tick();
    chk("rb_load_pending", mem_valid, 1);
    rollback = 1; tick(); rollback = 0;
    chk("rb_load_dropped", mem_valid, 0);
    mem_ready = 1;

    // IO load waits for the ROB head tag
    enq(0, IO, 0, 0, 0, 0, 4'd12);
    tick();
    chk("io_tag", io_rob_id, 12);
    chk("io_blocked", mem_valid, 0);
    head_io_rob_id = 4'd12;
    tick();
    chk("io_issue", mem_valid, 1);
    chk("io_addr", mem_addr, IO);
    head_io_rob_id = 0;
    tick();

    // fill to full, overflow ignored, then drain with wrap
    for (int k = 0; k < DEPTH; k++) begin
      enq(1, k, k, 0, 0, 0, 4'(k % 15 + 1));
      chk("fill_af", almost_full, (k + 1) >= 11);
    end
    chk("full_count", count, 16);
    enq(1, 32'h99, 0, 0, 0, 0, 4'd1);
    chk("full_ignore", count, 16);
    rollback = 1; tick(); rollback = 0;
    chk("flush_count", count, 0);
    for (int r = 0; r < 20; r++) begin
      enq(1, r * 16, r, 0, 0, 0, 4'(5 + r % 10));
      cmt(4'(5 + r % 10));
    end
    tick(); tick();
    chk("wrap_drain", count, 0);

    // asynchronous reset in the middle of a handshake
    mem_ready = 0;
    enq(0, 32'h60, 0, 0, 0, 0, 4'd13);
    tick();
    chk("arst_pending", mem_valid, 1);
    #2 rst = 0;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_count", count, 0);
    model_reset();
    @(negedge clk) rst = 1;

    for (int k = 0; k < 800; k++) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
